// File: rtl/sd_emmc_fifo_bridge_pkg.sv
// Shared constants and helpers for the SD/eMMC FIFO bridge.
package sd_emmc_fifo_bridge_pkg;

    localparam int unsigned DEF_ADDR_W = 9;
    localparam int unsigned DEF_DATA_W = 32;

    // Sticky error vector layout.
    localparam int unsigned ERR_W   = 2;
    localparam int unsigned ERR_OVF = 0;
    localparam int unsigned ERR_UNF = 1;

    // Reverse byte order of a 32-bit word: {b3,b2,b1,b0} -> {b0,b1,b2,b3}.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sd_emmc_fifo_bridge_if.sv
// Bus bundle between the SDMA engine / card datapath and the FIFO bridge.
// master = engine/serdes side, slave = bridge.
interface sd_emmc_fifo_bridge_if #(
    parameter int unsigned ADDR_W = sd_emmc_fifo_bridge_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = sd_emmc_fifo_bridge_pkg::DEF_DATA_W
) ();

    logic              fifo_rst;
    logic              fifo_dat_wr_ready;
    logic [DATA_W-1:0] axi_rdata;
    logic              fifo_dat_rd_ready;
    logic [DATA_W-1:0] axi_wdata;
    logic              ser_rd;
    logic [DATA_W-1:0] ser_dat;
    logic              deser_we;
    logic [DATA_W-1:0] deser_dat;
    logic              tx_empty;
    logic              tx_full;
    logic              rx_empty;
    logic              rx_full;
    logic [ADDR_W:0]   tx_count;
    logic [ADDR_W:0]   rx_count;
    logic [1:0]        fifo_err;

    modport master (
        output fifo_rst, fifo_dat_wr_ready, axi_rdata, fifo_dat_rd_ready,
               ser_rd, deser_we, deser_dat,
        input  axi_wdata, ser_dat, tx_empty, tx_full, rx_empty, rx_full,
               tx_count, rx_count, fifo_err
    );

    modport slave (
        input  fifo_rst, fifo_dat_wr_ready, axi_rdata, fifo_dat_rd_ready,
               ser_rd, deser_we, deser_dat,
        output axi_wdata, ser_dat, tx_empty, tx_full, rx_empty, rx_full,
               tx_count, rx_count, fifo_err
    );

endinterface

// File: rtl/sd_emmc_fifo_bridge_word_fifo.sv
// Single-clock first-word-fall-through word FIFO with count, flags and
// overflow/underflow pulses. Memory is not cleared by reset or flush.
module sd_emmc_word_fifo
    import sd_emmc_fifo_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ovf_c,
    output logic              unf_c
);

    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic              do_push;
    logic              do_pop;

    // Qualify requests against flags and compute next pointers/count.
    always_comb begin
        do_pop     = pop & ~empty & ~flush;
        do_push    = push & (~full | pop) & ~flush;
        ovf_c      = push & full & ~pop & ~flush;
        unf_c      = pop & empty & ~flush;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (do_push) wr_ptr_nxt = wr_ptr + ADDR_W'(1);
            if (do_pop)  rd_ptr_nxt = rd_ptr + ADDR_W'(1);
            if (do_push && !do_pop)
                count_nxt = count + (ADDR_W + 1)'(1);
            else if (!do_push && do_pop)
                count_nxt = count - (ADDR_W + 1)'(1);
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            full   <= (count_nxt == CNT_FULL);
            empty  <= (count_nxt == '0);
        end
    end

    // Storage write port; contents survive reset and flush.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/sd_emmc_fifo_bridge.sv
// SD/eMMC dual FIFO bridge: tx (host->card) and rx (card->host) word FIFOs,
// host strobe edge detection and sticky error flags.
// Optional build macro: SD_FIFO_BYTE_SWAP_EN byte-reverses host-side words.
module sd_emmc_fifo_bridge
    import sd_emmc_fifo_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic clock,
    input  logic reset,
    sd_emmc_fifo_bridge_if.slave bus
);

    logic              wr_prev;
    logic              rd_prev;
    logic              wr_ev;
    logic              rd_ev;
    logic              tx_ovf;
    logic              tx_unf;
    logic              rx_ovf;
    logic              rx_unf;
    logic [DATA_W-1:0] tx_wdata;
    logic [DATA_W-1:0] rx_rdata;
    logic [ERR_W-1:0]  err_nxt;

    // Previous-value flops for the host strobes; cleared by flush.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_prev <= 1'b0;
            rd_prev <= 1'b0;
        end else if (bus.fifo_rst) begin
            wr_prev <= 1'b0;
            rd_prev <= 1'b0;
        end else begin
            wr_prev <= bus.fifo_dat_wr_ready;
            rd_prev <= bus.fifo_dat_rd_ready;
        end
    end

    // Rising-edge events; an edge coincident with flush is discarded.
    assign wr_ev = bus.fifo_dat_wr_ready & ~wr_prev & ~bus.fifo_rst;
    assign rd_ev = bus.fifo_dat_rd_ready & ~rd_prev & ~bus.fifo_rst;

`ifdef SD_FIFO_BYTE_SWAP_EN
    // Host-side byte reversal in both directions.
    assign tx_wdata      = byte_swap32(bus.axi_rdata);
    assign bus.axi_wdata = byte_swap32(rx_rdata);
`else
    // Host-side pass-through.
    assign tx_wdata      = bus.axi_rdata;
    assign bus.axi_wdata = rx_rdata;
`endif

    sd_emmc_word_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .flush (bus.fifo_rst),
        .push  (wr_ev),
        .pop   (bus.ser_rd),
        .wdata (tx_wdata),
        .rdata (bus.ser_dat),
        .count (bus.tx_count),
        .full  (bus.tx_full),
        .empty (bus.tx_empty),
        .ovf_c (tx_ovf),
        .unf_c (tx_unf)
    );

    sd_emmc_word_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .flush (bus.fifo_rst),
        .push  (bus.deser_we),
        .pop   (rd_ev),
        .wdata (bus.deser_dat),
        .rdata (rx_rdata),
        .count (bus.rx_count),
        .full  (bus.rx_full),
        .empty (bus.rx_empty),
        .ovf_c (rx_ovf),
        .unf_c (rx_unf)
    );

    // Merge this cycle's error pulses into the sticky vector.
    always_comb begin
        err_nxt          = bus.fifo_err;
        err_nxt[ERR_OVF] = bus.fifo_err[ERR_OVF] | tx_ovf | rx_ovf;
        err_nxt[ERR_UNF] = bus.fifo_err[ERR_UNF] | tx_unf | rx_unf;
    end

    // Sticky error register; cleared by reset or flush.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.fifo_err <= '0;
        end else if (bus.fifo_rst) begin
            bus.fifo_err <= '0;
        end else begin
            bus.fifo_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sd_emmc_fifo_bridge.sv
// Directed self-checking bench for sd_emmc_fifo_bridge (ADDR_W = 9).
module tb_sd_emmc_fifo_bridge;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    sd_emmc_fifo_bridge_if bus ();

    sd_emmc_fifo_bridge dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected host-side word for a given stored/card-side word.
    function automatic logic [31:0] host_word(input logic [31:0] w);
`ifdef SD_FIFO_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    initial begin
        checks                = 0;
        errors                = 0;
        reset                 = 1'b0;
        bus.fifo_rst          = 1'b0;
        bus.fifo_dat_wr_ready = 1'b0;
        bus.axi_rdata         = '0;
        bus.fifo_dat_rd_ready = 1'b0;
        bus.ser_rd            = 1'b0;
        bus.deser_we          = 1'b0;
        bus.deser_dat         = '0;

        // Reset, then idle.
        tick(3);
        reset = 1'b1;
        tick(5);
        check("rst_tx_empty", 32'(bus.tx_empty), 32'd1);
        check("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
        check("rst_tx_full",  32'(bus.tx_full),  32'd0);
        check("rst_rx_full",  32'(bus.rx_full),  32'd0);
        check("rst_tx_count", 32'(bus.tx_count), 32'd0);
        check("rst_rx_count", 32'(bus.rx_count), 32'd0);
        check("rst_fifo_err", 32'(bus.fifo_err), 32'd0);

        // Strobe held high 3 cycles pushes exactly once.
        bus.fifo_dat_wr_ready = 1'b1;
        bus.axi_rdata         = 32'hA5A5_0001;
        tick(1);
        check("tx_cnt_first_edge", 32'(bus.tx_count), 32'd1);
        tick(2);
        bus.fifo_dat_wr_ready = 1'b0;
        tick(1);
        check("tx_cnt_held", 32'(bus.tx_count), 32'd1);
        check("tx_not_empty", 32'(bus.tx_empty), 32'd0);
        check("ser_dat_head", bus.ser_dat, host_word(32'hA5A5_0001));
        bus.ser_rd = 1'b1;
        tick(1);
        bus.ser_rd = 1'b0;
        check("tx_empty_after_pop", 32'(bus.tx_empty), 32'd1);
        check("tx_cnt_after_pop",   32'(bus.tx_count), 32'd0);
        check("err_after_tx_pop",   32'(bus.fifo_err), 32'd0);

        // Fill rx with 0..511.
        bus.deser_we = 1'b1;
        for (int i = 0; i < 512; i++) begin
            bus.deser_dat = 32'(i);
            tick(1);
        end
        bus.deser_we = 1'b0;
        check("rx_full",      32'(bus.rx_full),  32'd1);
        check("rx_cnt_full",  32'(bus.rx_count), 32'd512);
        check("rx_head_zero", bus.axi_wdata, host_word(32'd0));

        // Push together with pop edge while full: legal, count unchanged.
        bus.deser_we          = 1'b1;
        bus.deser_dat         = 32'd512;
        bus.fifo_dat_rd_ready = 1'b1;
        tick(1);
        bus.deser_we = 1'b0;
        check("rx_cnt_pushpop_full", 32'(bus.rx_count), 32'd512);
        check("err_pushpop_full",    32'(bus.fifo_err), 32'd0);
        check("rx_full_pushpop",     32'(bus.rx_full),  32'd1);

        // Overflow push (rd_ready still high, no new edge).
        bus.deser_we  = 1'b1;
        bus.deser_dat = 32'd999;
        tick(1);
        bus.deser_we          = 1'b0;
        bus.fifo_dat_rd_ready = 1'b0;
        check("err_ovf",     32'(bus.fifo_err), 32'd1);
        check("rx_cnt_ovf",  32'(bus.rx_count), 32'd512);
        tick(1);

        // Drain 512 words with rd_ready pulses; contents are 1..512.
        for (int k = 0; k < 512; k++) begin
            check("rx_head_seq", bus.axi_wdata, host_word(32'(k + 1)));
            bus.fifo_dat_rd_ready = 1'b1;
            tick(1);
            bus.fifo_dat_rd_ready = 1'b0;
            tick(1);
        end
        check("rx_empty_drained", 32'(bus.rx_empty), 32'd1);
        check("rx_cnt_drained",   32'(bus.rx_count), 32'd0);
        check("err_after_drain",  32'(bus.fifo_err), 32'd1);

        // Flush clears sticky overflow.
        bus.fifo_rst = 1'b1;
        tick(1);
        bus.fifo_rst = 1'b0;
        check("err_flush1", 32'(bus.fifo_err), 32'd0);

        // Serializer pop on empty tx -> underflow.
        bus.ser_rd = 1'b1;
        tick(1);
        bus.ser_rd = 1'b0;
        check("err_unf_tx", 32'(bus.fifo_err), 32'd2);
        bus.fifo_rst = 1'b1;
        tick(1);
        bus.fifo_rst = 1'b0;
        check("err_flush2", 32'(bus.fifo_err), 32'd0);

        // Pop edge on empty rx with simultaneous push: push done, underflow flagged.
        bus.deser_we          = 1'b1;
        bus.deser_dat         = 32'h0000_0077;
        bus.fifo_dat_rd_ready = 1'b1;
        tick(1);
        bus.deser_we          = 1'b0;
        bus.fifo_dat_rd_ready = 1'b0;
        check("err_unf_rx",     32'(bus.fifo_err), 32'd2);
        check("rx_cnt_unfpush", 32'(bus.rx_count), 32'd1);
        check("rx_head_unfpush", bus.axi_wdata, host_word(32'h0000_0077));
        bus.fifo_rst = 1'b1;
        tick(1);
        bus.fifo_rst = 1'b0;
        check("rx_cnt_flush", 32'(bus.rx_count), 32'd0);
        check("rx_empty_flush", 32'(bus.rx_empty), 32'd1);

        // Push 100 words to tx.
        for (int i = 0; i < 100; i++) begin
            bus.fifo_dat_wr_ready = 1'b1;
            bus.axi_rdata         = 32'h0000_1000 + 32'(i);
            tick(1);
            bus.fifo_dat_wr_ready = 1'b0;
            tick(1);
        end
        check("tx_cnt_100",   32'(bus.tx_count), 32'd100);
        check("tx_head_100",  bus.ser_dat, host_word(32'h0000_1000));

        // Flush coincident with a wr_ready edge: edge discarded.
        bus.fifo_rst          = 1'b1;
        bus.fifo_dat_wr_ready = 1'b1;
        bus.axi_rdata         = 32'hDEAD_BEEF;
        tick(1);
        bus.fifo_rst          = 1'b0;
        bus.fifo_dat_wr_ready = 1'b0;
        check("tx_cnt_flush_edge",   32'(bus.tx_count), 32'd0);
        check("tx_empty_flush_edge", 32'(bus.tx_empty), 32'd1);
        check("err_flush_edge",      32'(bus.fifo_err), 32'd0);
        tick(2);
        check("tx_cnt_flush_later",  32'(bus.tx_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
